mul_div_unit: RTL and testbench
===============================

# mul_div_unit

RV32M multiply/divide unit in the EX stage, directly downstream of the forwarding unit. It takes the already-forwarded rs1/rs2 operand values and produces the M-extension result. Multiplies and divide special cases finish in one cycle; regular divides iterate for 32 cycles while the hazard logic stalls IF/ID/EX.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  EX holds an M-extension op; held high by the pipeline until `done`.
- kill  in  1  EX flush (branch/exception); aborts any operation in progress.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  32  forwarded rs1 value.
- op_b  in  32  forwarded rs2 value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; `result` is valid.
- result  out  32  M-extension result; held from `done` until the next accepted start.

## Operation
- States: IDLE, DIV_RUN, DONE.
- **IDLE, accepting an op:** on `start=1` and `kill=0`, latch `funct3`, `op_a` and `op_b`.
  - Multiply op, or divide by zero, or signed overflow: compute `result`, go to DONE.
  - Any other divide: go to DIV_RUN with the iteration counter at 0.
- **Operand signedness:**
  - `op_a` is signed for MULH, MULHSU, DIV and REM.
  - `op_b` is signed for MULH, DIV and REM only.
- **Multiply:** full 64-bit product.
  - MUL returns product bits [31:0].
  - MULH, MULHSU and MULHU return product bits [63:32].
- **Divide by zero (`op_b=0`):**
  - DIV and DIVU return 0xFFFFFFFF.
  - REM and REMU return `op_a`.
- **Signed overflow (`op_a=0x80000000`, `op_b=0xFFFFFFFF`):**
  - DIV returns 0x80000000.
  - REM returns 0.
- **DIV_RUN:**
  - Take the magnitudes of the signed operands.
  - Run an unsigned restoring divide, one quotient bit per cycle, MSB first.
  - Use a 33-bit partial remainder.
  - The counter runs 0..31; after iteration 31, go to DONE.
- **Sign fix, applied in DONE:**
  - The quotient is negated when the operand signs differ (signed ops only).
  - The remainder takes the sign of the dividend.
  - A zero remainder stays 0.
- **DONE:** `done=1` for exactly one cycle, then go to IDLE unconditionally.
  - `start` seen in DONE is ignored, because the pipeline advances on `done`.
- **kill:**
  - In DIV_RUN or DONE, `kill` forces IDLE on the next edge.
  - If the DONE cycle itself is killed, `done` is suppressed.
  - `result` is not updated by a killed operation.
  - `kill` has priority over `start` in the same cycle.
- **Reset values:** `busy=0`, `done=0`, `result=0`, state IDLE, counter 0, all internal operand registers 0.
  - Reset mid-division discards the operation immediately.

## Timing
- Define cycle 0 as the cycle in which `start` is accepted in IDLE.
- **Multiply or special-case divide:** DONE in cycle 1 (`done` and `busy` high); IDLE in cycle 2.
- **Regular divide:**
  - DIV_RUN occupies cycles 1..32.
  - DONE is cycle 33.
  - IDLE in cycle 34.
- **Stall request:** the hazard unit forms it as `start & ~done`, so EX is frozen from cycle 0 up to, but not including, the `done` cycle.
- **Back-to-back ops:** the earliest next accepted start is the cycle after DONE, i.e. the IDLE cycle.
- **Operand stability:** `op_a`, `op_b` and `funct3` changing after cycle 0 have no effect, since all are latched.
- **result timing:** `result` changes only on the edge that enters DONE.
- **Divider datapath:** width 33 bits; a subtraction borrow clears the quotient bit and restores the partial remainder.

## Test plan
- **MULH (signed):** `op_a=0x80000000`, `op_b=0x80000000` -> `result=0x40000000`, `done` in cycle 1.
- **MULHSU and MUL:**
  - MULHSU with `op_a=0xFFFFFFFF` (-1), `op_b=0xFFFFFFFF` -> `result=0xFFFFFFFF`.
  - MUL with `op_a=7`, `op_b=6` -> `result=0x0000002A`.
- **Signed divide, negative dividend:**
  - DIV -7/2 -> `result=0xFFFFFFFD`, `done` in cycle 33, `busy` high cycles 1..33.
  - REM -7/2 -> `result=0xFFFFFFFF`.
- **Special cases:**
  - DIVU 5/0 -> `result=0xFFFFFFFF`, `done` in cycle 1.
  - REMU 5/0 -> `result=5`.
  - DIV 0x80000000/0xFFFFFFFF -> `result=0x80000000`, `done` in cycle 1.
- **Kill mid-divide:**
  - Start DIVU 100/3 and assert `kill` in cycle 10 -> no `done`, `busy=0` from cycle 11, `result` unchanged.
  - Then a new DIVU 100/3 -> `result=33`.
  - REMU 100/3 -> `result=1`.
- **Reset and back-to-back:**
  - Assert `rst` asynchronously mid-DIV_RUN -> `busy`, `done` and `result` go to 0 immediately.
  - After release: MUL 3*4 immediately followed by DIV 12/-4 -> results 12 then 0xFFFFFFFD.
  - `start` held through DONE must not retrigger.

Source files
------------

// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit for the EX stage: single-cycle multiply and divide
// special cases, 32-cycle restoring divide for everything else.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        kill,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, DIV_RUN, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic        rem_op_q;
    logic        neg_q, neg_r;
    logic [31:0] a_q, b_q;
    logic [32:0] rem_q;

    logic        a_signed, b_signed, a_neg, b_neg;
    logic        is_div, div_zero, overflow, div_iterate;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] mul_res, special_res, a_mag, b_mag;
    logic [33:0] shifted;
    logic [32:0] sub, rem_next;
    logic        take;
    logic [31:0] quo_next, quo_fix, rem_fix, div_res;

    // Operand decode and the single-cycle paths, evaluated on the accept cycle
    assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign a_neg    = a_signed & op_a[31];
    assign b_neg    = b_signed & op_b[31];
    assign a_ext    = {{32{a_neg}}, op_a};
    assign b_ext    = {{32{b_neg}}, op_b};
    assign prod     = a_ext * b_ext;
    assign mul_res  = (funct3 == 3'b000) ? prod[31:0] : prod[63:32];

    assign is_div      = funct3[2];
    assign div_zero    = (op_b == 32'd0);
    assign overflow    = ~funct3[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    assign div_iterate = is_div && !div_zero && !overflow;
    assign special_res = div_zero ? (funct3[1] ? op_a : 32'hFFFF_FFFF)
                                  : (funct3[1] ? 32'd0 : 32'h8000_0000);
    assign a_mag       = a_neg ? -op_a : op_a;
    assign b_mag       = b_neg ? -op_b : op_b;

    // One restoring step: a_q shifts the dividend out MSB first and the quotient in
    assign shifted  = {rem_q, a_q[31]};
    assign take     = (shifted >= {2'b00, b_q});
    assign sub      = shifted[32:0] - {1'b0, b_q};
    assign rem_next = take ? sub : shifted[32:0];
    assign quo_next = {a_q[30:0], take};
    assign quo_fix  = neg_q ? -quo_next : quo_next;
    assign rem_fix  = neg_r ? -rem_next[31:0] : rem_next[31:0];
    assign div_res  = rem_op_q ? rem_fix : quo_fix;

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !kill)
                    state_next = div_iterate ? DIV_RUN : DONE;
            end
            DIV_RUN: begin
                if (kill)
                    state_next = IDLE;
                else if (cnt == 5'd31)
                    state_next = DONE;
            end
            DONE: begin
                done       = !kill;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // result is only written on the edge entering DONE, so a kill never corrupts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            rem_op_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            rem_q    <= 33'd0;
            result   <= 32'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start && !kill) begin
                        rem_op_q <= funct3[1];
                        cnt      <= 5'd0;
                        rem_q    <= 33'd0;
                        if (div_iterate) begin
                            a_q   <= a_mag;
                            b_q   <= b_mag;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                        end else begin
                            a_q    <= op_a;
                            b_q    <= op_b;
                            neg_q  <= 1'b0;
                            neg_r  <= 1'b0;
                            result <= is_div ? special_res : mul_res;
                        end
                    end
                end
                DIV_RUN: begin
                    if (!kill) begin
                        a_q   <= quo_next;
                        rem_q <= rem_next;
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd31)
                            result <= div_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against a plain-arithmetic RV32M model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_exp = 32'd0;

    mul_div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r  = 0;
        case (f3)
            3'b000: r = sa * sb;
            3'b001: begin r = sa * sb; r = r >>> 32; end
            3'b010: begin r = sa * ub; r = r >>> 32; end
            3'b011: begin r = ua * ub; r = r >> 32; end
            3'b100: r = (b == 0) ? -1 : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? sa : sa / sb;
            3'b101: r = (b == 0) ? -1 : ua / ub;
            3'b110: r = (b == 0) ? sa : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 0 : sa % sb;
            default: r = (b == 0) ? ua : ua % ub;
        endcase
        return r[31:0];
    endfunction

    function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        if (f3 < 3'b100 || b == 0) return 1;
        if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts one op at the current IDLE cycle, holds start through DONE and scrambles operands
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res;
        int exp_lat, cyc, busy_low;
        bit seen;
        exp_res  = refResult(f3, a, b);
        exp_lat  = refLatency(f3, a, b);
        funct3   = f3;
        op_a     = a;
        op_b     = b;
        start    = 1'b1;
        cyc      = 0;
        busy_low = 0;
        seen     = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            funct3 = 3'($urandom);
            op_a   = $urandom;
            op_b   = $urandom;
            if (!busy) busy_low++;
            if (done) seen = 1'b1;
        end
        checkOutput("latency", 32'(cyc), 32'(exp_lat));
        checkOutput("busy_run", 32'(busy_low), 32'd0);
        checkOutput("result", result, exp_res);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("result_hold", result, exp_res);
        last_exp = exp_res;
    endtask

    initial begin
        #2;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(3'b001, 32'h8000_0000, 32'h8000_0000);
        applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(3'b000, 32'd7, 32'd6);
        applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(3'b101, 32'd5, 32'd0);
        applyStimulus(3'b111, 32'd5, 32'd0);
        applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);

        // Kill in cycle 10 of a divide; kill also beats start in the following IDLE cycle
        funct3 = 3'b101;
        op_a   = 32'd100;
        op_b   = 32'd3;
        start  = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        kill = 1'b1;
        checkOutput("kill_c10_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("kill_busy", 32'(busy), 32'd0);
        checkOutput("kill_done", 32'(done), 32'd0);
        checkOutput("kill_result", result, last_exp);
        @(posedge clk);
        #1;
        checkOutput("kill_prio_busy", 32'(busy), 32'd0);
        kill  = 1'b0;
        start = 1'b0;
        applyStimulus(3'b101, 32'd100, 32'd3);
        applyStimulus(3'b111, 32'd100, 32'd3);

        // Asynchronous reset in the middle of DIV_RUN
        funct3 = 3'b100;
        op_a   = 32'd1000;
        op_b   = 32'd7;
        start  = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_done", 32'(done), 32'd0);
        checkOutput("arst_result", result, 32'd0);
        start = 1'b0;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(3'b000, 32'd3, 32'd4);
        applyStimulus(3'b100, 32'd12, 32'hFFFF_FFFC);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin
                    a = $urandom_range(0, 200);
                    b = $urandom_range(1, 9);
                    if ($urandom_range(0, 1) == 1) b = -b;
                    if ($urandom_range(0, 1) == 1) a = -a;
                end
                default: ;
            endcase
            applyStimulus(f3, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
